// File: rtl/alu_seq_core.sv
// alu_seq_core: N-bit ALU under a start/done handshake; ADD/SUB/logic/shift in one EXEC cycle, MUL/DIV/MOD iterative.
// Latency: done 2 cycles after start for single-cycle ops, N+1 cycles for MUL/DIV/MOD; outputs hold until the next done.
// Backpressure: none; start is sampled only while busy=0 (IDLE or DONE) and is dropped, not queued, while busy=1.
// Build option ALU_DIV_EN: when defined, the restoring divider (DIV/MOD) is compiled in; otherwise opcodes 3/4 are illegal.
module alu_seq_core #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic [3:0]   flags,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int CW = $clog2(N);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // acc holds the running high product word (MUL) or partial remainder (DIV/MOD);
    // lo holds the multiplier being shifted out (MUL) or the dividend/quotient (DIV/MOD).
    logic [N-1:0]    acc_q, acc_d;
    logic [N-1:0]    lo_q, lo_d;
    logic [N-1:0]    result_q, result_d;
    logic [N-1:0]    result_hi_q, result_hi_d;
    logic [3:0]      flags_q, flags_d;
    logic            err_q, err_d;

    logic            is_iter_op;
    logic [N:0]      ex_sum;
    logic [N:0]      ex_diff;
    logic [N:0]      ex_shl;
    logic [N:0]      ex_shr;
    logic [N-1:0]    ex_res;
    logic            ex_c;
    logic            ex_v;
    logic            ex_err;
    logic [3:0]      ex_flags;
    logic [N:0]      mul_sum;
    logic [N-1:0]    mul_acc_nx;
    logic [N-1:0]    mul_lo_nx;
`ifdef ALU_DIV_EN
    logic [N:0]      div_rsh;
    logic            div_ge;
    logic [N-1:0]    div_acc_nx;
    logic [N-1:0]    div_lo_nx;
`endif

    // Decode which incoming opcodes take the iterative path.
    always_comb begin
        is_iter_op = (op == OP_MUL);
`ifdef ALU_DIV_EN
        if ((op == OP_DIV) || (op == OP_MOD)) begin
            is_iter_op = 1'b1;
        end
`endif
    end

    // Single-cycle datapath for the EXEC state; illegal opcodes zero everything and raise err.
    always_comb begin
        ex_sum  = {1'b0, a_q} + {1'b0, b_q};
        ex_diff = {1'b0, a_q} - {1'b0, b_q};
        // Extra bit beside the shifted word captures the last bit pushed out; it reads 0 for b==0 or b>N.
        ex_shl  = {1'b0, a_q} << b_q;
        ex_shr  = {a_q, 1'b0} >> b_q;
        ex_res  = '0;
        ex_c    = 1'b0;
        ex_v    = 1'b0;
        ex_err  = 1'b0;
        case (op_q)
            OP_ADD: begin
                ex_res = ex_sum[N-1:0];
                ex_c   = ex_sum[N];
                ex_v   = (a_q[N-1] == b_q[N-1]) && (ex_sum[N-1] != a_q[N-1]);
            end
            OP_SUB: begin
                ex_res = ex_diff[N-1:0];
                ex_c   = ex_diff[N];
                ex_v   = (a_q[N-1] != b_q[N-1]) && (ex_diff[N-1] != a_q[N-1]);
            end
            OP_AND: ex_res = a_q & b_q;
            OP_XOR: ex_res = a_q ^ b_q;
            OP_OR:  ex_res = a_q | b_q;
            OP_SHL: begin
                ex_res = ex_shl[N-1:0];
                ex_c   = ex_shl[N];
            end
            OP_SHR: begin
                ex_res = ex_shr[N:1];
                ex_c   = ex_shr[0];
            end
            default: ex_err = 1'b1;
        endcase
        ex_flags = ex_err ? 4'b0000 : {ex_v, ex_res[N-1], (ex_res == '0), ex_c};
    end

    // One shift-add multiply step: add a when the multiplier LSB is set, then shift {acc,lo} right.
    always_comb begin
        mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_q} : {(N+1){1'b0}});
        mul_acc_nx = mul_sum[N:1];
        mul_lo_nx  = {mul_sum[0], lo_q[N-1:1]};
    end

`ifdef ALU_DIV_EN
    // One restoring-divide step; with b==0 every trial succeeds, giving all-ones quotient and remainder a.
    always_comb begin
        div_rsh    = {acc_q, lo_q[N-1]};
        div_ge     = (div_rsh >= {1'b0, b_q});
        div_acc_nx = div_ge ? N'(div_rsh - {1'b0, b_q}) : div_rsh[N-1:0];
        div_lo_nx  = {lo_q[N-2:0], div_ge};
    end
`endif

    // Next-state and register-update logic; outputs only change on entry to DONE.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        lo_d        = lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        err_d       = err_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cnt_d   = CW'(N - 1);
                    acc_d   = '0;
                    lo_d    = (op == OP_MUL) ? b : a;
                    state_d = is_iter_op ? S_ITER : S_EXEC;
                end
            end
            S_EXEC: begin
                result_d    = ex_res;
                result_hi_d = '0;
                flags_d     = ex_flags;
                err_d       = ex_err;
                state_d     = S_DONE;
            end
            S_ITER: begin
                cnt_d = cnt_q - CW'(1);
`ifdef ALU_DIV_EN
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc_nx;
                    lo_d  = mul_lo_nx;
                end else begin
                    acc_d = div_acc_nx;
                    lo_d  = div_lo_nx;
                end
`else
                acc_d = mul_acc_nx;
                lo_d  = mul_lo_nx;
`endif
                if (cnt_q == '0) begin
                    state_d     = S_DONE;
                    err_d       = 1'b0;
                    result_d    = mul_lo_nx;
                    result_hi_d = mul_acc_nx;
                    flags_d     = {(mul_acc_nx != '0), 1'b0, ({mul_acc_nx, mul_lo_nx} == '0), 1'b0};
`ifdef ALU_DIV_EN
                    if (op_q == OP_DIV) begin
                        result_d    = div_lo_nx;
                        result_hi_d = '0;
                        flags_d     = {(b_q == '0), 1'b0, (div_lo_nx == '0), 1'b0};
                    end else if (op_q == OP_MOD) begin
                        result_d    = div_acc_nx;
                        result_hi_d = '0;
                        flags_d     = {(b_q == '0), 1'b0, (div_acc_nx == '0), 1'b0};
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;
    assign err       = err_q;
    assign busy      = (state_q == S_EXEC) || (state_q == S_ITER);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core (N=4): stimulus pushes expected responses, a monitor checks each done.
module tb_alu_seq_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] result;
    logic [3:0] result_hi;
    logic [3:0] flags;
    logic       busy;
    logic       done;
    logic       err;

    alu_seq_core #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic [3:0] res;
        logic [3:0] hi;
        logic [3:0] flg;
        logic       e;
        int         lat;
        int         t0;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: every done pops one expectation and compares outputs and latency.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 (result=%0d) expected no done", result);
            end else begin
                e = sb.pop_front();
                chk({e.name, ".result"},    int'(result),    int'(e.res));
                chk({e.name, ".result_hi"}, int'(result_hi), int'(e.hi));
                chk({e.name, ".flags"},     int'(flags),     int'(e.flg));
                chk({e.name, ".err"},       int'(err),       int'(e.e));
                chk({e.name, ".latency"},   cyc - e.t0,      e.lat);
                chk({e.name, ".busy_at_done"}, int'(busy),   0);
            end
        end
    end

    // Present an op at a negedge, wait (bounded) until it is accepted, optionally record the expectation.
    task automatic issue(input string nm, input logic [3:0] o, input logic [3:0] aa, input logic [3:0] bb,
                         input logic [3:0] er, input logic [3:0] eh, input logic [3:0] ef, input logic ee,
                         input int el, input bit hold, input bit push);
        int   guard;
        exp_t e;
        @(negedge clk);
        op    = o;
        a     = aa;
        b     = bb;
        start = 1'b1;
        guard = 0;
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL %s.accept_timeout: busy=1 expected 0", nm);
        end
        if (push) begin
            e.name = nm;
            e.res  = er;
            e.hi   = eh;
            e.flg  = ef;
            e.e    = ee;
            e.lat  = el;
            e.t0   = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        if (!hold) begin
            #1;
            start = 1'b0;
        end
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 4'd0;
        a     = 4'd0;
        b     = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset.result",    int'(result),    0);
        chk("reset.result_hi", int'(result_hi), 0);
        chk("reset.flags",     int'(flags),     0);
        chk("reset.busy",      int'(busy),      0);
        chk("reset.done",      int'(done),      0);
        chk("reset.err",       int'(err),       0);

        // ADD 9+8 = 17: result 1, carry and signed overflow
        issue("add_9_8", 4'd0, 4'd9, 4'd8, 4'd1, 4'd0, 4'b1001, 1'b0, 2, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Reset mid-MUL: no done, outputs cleared
        issue("mul_rst", 4'd2, 4'd7, 4'd6, 4'd0, 4'd0, 4'd0, 1'b0, 5, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.result",    int'(result),    0);
        chk("midrst.result_hi", int'(result_hi), 0);
        chk("midrst.flags",     int'(flags),     0);
        chk("midrst.busy",      int'(busy),      0);
        chk("midrst.done",      int'(done),      0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // SUB 3-5 = -2: borrow, negative
        issue("sub_3_5", 4'd1, 4'd3, 4'd5, 4'hE, 4'd0, 4'b0101, 1'b0, 2, 1'b0, 1'b1);

        // MUL 7*6 = 42 = 0x2A, with ignored start pulses while busy
        issue("mul_7_6", 4'd2, 4'd7, 4'd6, 4'hA, 4'h2, 4'b1000, 1'b0, 5, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            start = 1'b1;
            op    = 4'd0;
            a     = 4'd1;
            b     = 4'd1;
        end
        @(negedge clk);
        start = 1'b0;

`ifdef ALU_DIV_EN
        issue("div_13_4", 4'd3, 4'd13, 4'd4, 4'd3, 4'd0, 4'b0000, 1'b0, 5, 1'b0, 1'b1);
        issue("mod_13_4", 4'd4, 4'd13, 4'd4, 4'd1, 4'd0, 4'b0000, 1'b0, 5, 1'b0, 1'b1);
        issue("div_13_0", 4'd3, 4'd13, 4'd0, 4'hF, 4'd0, 4'b1000, 1'b0, 5, 1'b0, 1'b1);
`else
        issue("div_off",  4'd3, 4'd13, 4'd4, 4'd0, 4'd0, 4'b0000, 1'b1, 2, 1'b0, 1'b1);
        issue("mod_off",  4'd4, 4'd13, 4'd4, 4'd0, 4'd0, 4'b0000, 1'b1, 2, 1'b0, 1'b1);
`endif

        // Shifts: SHL 1011<<1 = 0110 carry 1; SHR 1011>>4 = 0, last bit out a[3]=1, zero
        issue("shl_b_1", 4'd8, 4'b1011, 4'd1, 4'b0110, 4'd0, 4'b0001, 1'b0, 2, 1'b0, 1'b1);
        issue("shr_b_4", 4'd9, 4'b1011, 4'd4, 4'b0000, 4'd0, 4'b0011, 1'b0, 2, 1'b0, 1'b1);
        issue("xor_c_a", 4'd6, 4'hC, 4'hA, 4'h6, 4'd0, 4'b0000, 1'b0, 2, 1'b0, 1'b1);

        // Illegal opcode
        issue("ill_12", 4'd12, 4'd5, 4'd5, 4'd0, 4'd0, 4'b0000, 1'b1, 2, 1'b0, 1'b1);

        // Back-to-back with start held high: ADD, OR, ADD
        issue("b2b_add_2_3", 4'd0, 4'd2, 4'd3,  4'd5, 4'd0, 4'b0000, 1'b0, 2, 1'b1, 1'b1);
        issue("b2b_or_5_a",  4'd7, 4'd5, 4'hA,  4'hF, 4'd0, 4'b0100, 1'b0, 2, 1'b1, 1'b1);
        issue("b2b_add_7_1", 4'd0, 4'd7, 4'd1,  4'd8, 4'd0, 4'b1100, 1'b0, 2, 1'b0, 1'b1);

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
        end
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
